// File: rtl/led_pattern_sequencer_pkg.sv
// led_pattern_sequencer_pkg
// Shared PD1 I/O encodings used by the LED pattern sequencer and its helpers.
//   mode_t       : 2-bit pattern select carried on the board switches
//   MODE_*       : pattern encodings (ROT_L, ROT_R, BOUNCE, FILL)
//   DIR_*        : bounce direction encodings
package led_pattern_sequencer_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ROT_L  = 2'b00;
    localparam mode_t MODE_ROT_R  = 2'b01;
    localparam mode_t MODE_BOUNCE = 2'b10;
    localparam mode_t MODE_FILL   = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_sequencer_rise_edge_detect.sv
// rise_edge_detect
// Single-register rising-edge detector, intended for reuse on debounced
// buttons as well as the timer square wave.
//   clk   : system clock, posedge
//   rst   : synchronous active-high reset
//   din   : level input, same clock domain
//   pulse : combinational, high while din=1 and the previous sample was 0
// RESET_VAL is the value the history register takes in reset; 1 means a
// din that is already high when reset releases is not seen as an edge.
module rise_edge_detect
    import led_pattern_sequencer_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= RESET_VAL;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Advances an LED pattern one step per rising edge of the timer square wave.
//   clk        : system clock, posedge
//   rst        : synchronous active-high reset
//   tick_in    : timer square wave; each rising edge requests one step
//   mode       : 00 ROT_L, 01 ROT_R, 10 BOUNCE, 11 FILL
//   pause      : 1 drops step requests (they are not queued)
//   leds       : registered LED pattern, WIDTH bits
//   step_pulse : registered, one cycle when leds advanced
//   wrap_pulse : registered, one cycle when the pattern completed a cycle
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic [WIDTH-1:0] leds,
    output logic             step_pulse,
    output logic             wrap_pulse
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(WIDTH - 1);

    logic             tick_rise;
    mode_t            mode_q;
    logic             chg;
    logic             step;
    logic             dir;
    logic [IDX_W-1:0] fill_idx;

    logic [WIDTH-1:0] fill_pat;
    logic             is_onehot;
    logic             pattern_ok;
    logic [WIDTH-1:0] nxt_leds;
    logic             nxt_dir;
    logic [IDX_W-1:0] nxt_fill;
    logic             nxt_wrap;

    rise_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_tick_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (tick_in),
        .pulse (tick_rise)
    );

    // A mode change restarts the pattern and swallows any edge in that cycle.
    assign chg  = (mode != mode_q);
    assign step = tick_rise & ~pause & ~chg;

    // Expected FILL pattern for the current index: bits 0..fill_idx lit.
    always_comb begin
        fill_pat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fill_pat[i] = (IDX_W'(i) <= fill_idx);
        end
    end

    assign is_onehot = (leds != '0) && ((leds & (leds - WIDTH'(1))) == '0);

    // Next pattern if a step happens now. An inconsistent pattern (only
    // reachable through a glitch) is replaced by the start pattern.
    always_comb begin
        nxt_leds   = leds;
        nxt_dir    = dir;
        nxt_fill   = fill_idx;
        nxt_wrap   = 1'b0;
        pattern_ok = 1'b0;
        case (mode_q)
            MODE_ROT_L: begin
                pattern_ok = is_onehot;
                nxt_leds   = {leds[WIDTH-2:0], leds[WIDTH-1]};
                nxt_wrap   = leds[WIDTH-1];
            end
            MODE_ROT_R: begin
                pattern_ok = is_onehot;
                nxt_leds   = {leds[0], leds[WIDTH-1:1]};
                nxt_wrap   = leds[0];
            end
            MODE_BOUNCE: begin
                // The turn happens on the step that reaches the end bit, so
                // a lit end bit with direction still pointing outward is bad.
                pattern_ok = is_onehot
                           && !((dir == DIR_LEFT)  && leds[WIDTH-1])
                           && !((dir == DIR_RIGHT) && leds[0]);
                if (dir == DIR_LEFT) begin
                    nxt_leds = leds << 1;
                    if (nxt_leds[WIDTH-1]) begin
                        nxt_dir = DIR_RIGHT;
                    end
                end else begin
                    nxt_leds = leds >> 1;
                    if (nxt_leds[0]) begin
                        nxt_dir  = DIR_LEFT;
                        nxt_wrap = 1'b1;
                    end
                end
            end
            default: begin
                pattern_ok = (leds == fill_pat);
                if (fill_idx == FILL_LAST) begin
                    nxt_fill = '0;
                    nxt_leds = WIDTH'(1);
                    nxt_wrap = 1'b1;
                end else begin
                    nxt_fill = fill_idx + 1'b1;
                    nxt_leds = {leds[WIDTH-2:0], 1'b1};
                end
            end
        endcase
        if (!pattern_ok) begin
            nxt_leds = WIDTH'(1);
            nxt_dir  = DIR_LEFT;
            nxt_fill = '0;
            nxt_wrap = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds       <= WIDTH'(1);
            dir        <= DIR_LEFT;
            fill_idx   <= '0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            mode_q     <= mode;
        end else begin
            mode_q <= mode;
            if (chg) begin
                leds       <= WIDTH'(1);
                dir        <= DIR_LEFT;
                fill_idx   <= '0;
                step_pulse <= 1'b0;
                wrap_pulse <= 1'b0;
            end else if (step) begin
                leds       <= nxt_leds;
                dir        <= nxt_dir;
                fill_idx   <= nxt_fill;
                step_pulse <= 1'b1;
                wrap_pulse <= nxt_wrap;
            end else begin
                step_pulse <= 1'b0;
                wrap_pulse <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Self-checking bench for led_pattern_sequencer (WIDTH=8): a directed vector
// table, directed multi-edge sequences and a randomized run, all compared
// against a position/counter based reference model.
module tb_led_pattern_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         tick_in;
    logic [1:0]   mode;
    logic         pause;
    logic [W-1:0] leds;
    logic         step_pulse;
    logic         wrap_pulse;

    int numCompared;
    int numMismatched;

    led_pattern_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .mode       (mode),
        .pause      (pause),
        .leds       (leds),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lit position / bounce direction / fill count,
    // with the LED image derived arithmetically from them.
    int           mPos;
    bit           mUp;
    int           mFill;
    logic [W-1:0] mLeds;
    logic         mStep;
    logic         mWrap;
    logic         mPrevTick;
    logic [1:0]   mPrevMode;

    function automatic logic [W-1:0] posImage(input int p);
        logic [63:0] v;
        v = 64'd1 << p;
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] fillImage(input int k);
        logic [63:0] v;
        v = (64'd1 << (k + 1)) - 64'd1;
        return v[W-1:0];
    endfunction

    task automatic modelRestart();
        mPos  = 0;
        mUp   = 1'b1;
        mFill = 0;
        mLeds = posImage(0);
        mStep = 1'b0;
        mWrap = 1'b0;
    endtask

    task automatic modelStep(input logic r, input logic t, input logic [1:0] m, input logic p);
        if (r) begin
            modelRestart();
            mPrevTick = 1'b1;
            mPrevMode = m;
        end else begin
            if (m != mPrevMode) begin
                modelRestart();
            end else if (t && !mPrevTick && !p) begin
                mStep = 1'b1;
                mWrap = 1'b0;
                case (m)
                    2'd0: begin
                        mWrap = (mPos == W - 1);
                        mPos  = (mPos + 1) % W;
                        mLeds = posImage(mPos);
                    end
                    2'd1: begin
                        mWrap = (mPos == 0);
                        mPos  = (mPos + W - 1) % W;
                        mLeds = posImage(mPos);
                    end
                    2'd2: begin
                        if (mUp) begin
                            mPos = mPos + 1;
                            if (mPos == W - 1) mUp = 1'b0;
                        end else begin
                            mPos = mPos - 1;
                            if (mPos == 0) begin
                                mUp   = 1'b1;
                                mWrap = 1'b1;
                            end
                        end
                        mLeds = posImage(mPos);
                    end
                    default: begin
                        mWrap = (mFill == W - 1);
                        mFill = (mFill + 1) % W;
                        mLeds = fillImage(mFill);
                    end
                endcase
            end else begin
                mStep = 1'b0;
                mWrap = 1'b0;
            end
            mPrevTick = t;
            mPrevMode = m;
        end
    endtask

    // Drive one cycle of inputs, let the posedge take them, sample #1 later.
    task automatic applyStimulus(input logic r, input logic t, input logic [1:0] m, input logic p);
        rst     = r;
        tick_in = t;
        mode    = m;
        pause   = p;
        @(posedge clk);
        #1;
        modelStep(r, t, m, p);
    endtask

    task automatic checkOutput(input string name);
        numCompared++;
        if ({leds, step_pulse, wrap_pulse} !== {mLeds, mStep, mWrap}) begin
            numMismatched++;
            $display("[TB] FAIL %s @%0t: got leds=%h step=%b wrap=%b, want leds=%h step=%b wrap=%b",
                     name, $time, leds, step_pulse, wrap_pulse, mLeds, mStep, mWrap);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        numCompared++;
        if (act !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Low phase then high phase per edge; every cycle is checked against the
    // model and every step's LED image against the caller's expected list.
    task automatic runEdges(input int n, input int half, input logic [1:0] m,
                            input logic [W-1:0] seq [16],
                            output int steps, output int wraps, output int holds);
        logic [W-1:0] lastStepLeds;
        lastStepLeds = '0;
        steps = 0;
        wraps = 0;
        holds = 0;
        for (int e = 0; e < n; e++) begin
            for (int c = 0; c < 2 * half; c++) begin
                applyStimulus(1'b0, (c >= half), m, 1'b0);
                checkOutput("edgeRun");
                if (c == half) checkValue("stepLatency", 32'(step_pulse), 32'd1);
                if (step_pulse) begin
                    if (steps < 16) checkValue("stepSeq", 32'(leds), 32'(seq[steps]));
                    if (leds[W-1] && lastStepLeds[W-1]) holds++;
                    lastStepLeds = leds;
                    steps++;
                end
                if (wrap_pulse) wraps++;
            end
        end
    endtask

    typedef struct {
        logic         r;
        logic         t;
        logic [1:0]   m;
        logic         p;
        logic [W-1:0] eLeds;
        logic         eStep;
        logic         eWrap;
    } vec_t;

    vec_t vecs [18];

    logic [W-1:0] rotSeq    [16];
    logic [W-1:0] bounceSeq [16];
    logic [W-1:0] fillSeq   [16];

    initial begin
        int   steps;
        int   wraps;
        int   holds;
        logic rT;
        logic [1:0] rM;

        numCompared   = 0;
        numMismatched = 0;
        rst     = 1'b1;
        tick_in = 1'b0;
        mode    = 2'b00;
        pause   = 1'b0;
        mPrevTick = 1'b1;
        mPrevMode = 2'b00;
        modelRestart();

        // Pause and edge/mode collision walk from leds=04 in ROT_L.
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h04, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h08, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'd1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 2'd1, 1'b0, 8'h80, 1'b0, 1'b0};

        rotSeq    = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01,
                      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bounceSeq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                      8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        fillSeq   = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01,
                      8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        $display("[TB] vector table");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].r, vecs[i].t, vecs[i].m, vecs[i].p);
            numCompared++;
            if ({leds, step_pulse, wrap_pulse} !== {vecs[i].eLeds, vecs[i].eStep, vecs[i].eWrap}) begin
                numMismatched++;
                $display("[TB] FAIL vec%0d: got leds=%h step=%b wrap=%b, want leds=%h step=%b wrap=%b",
                         i, leds, step_pulse, wrap_pulse, vecs[i].eLeds, vecs[i].eStep, vecs[i].eWrap);
            end
        end

        $display("[TB] ROT_L, 42-cycle tick");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        checkOutput("resetRot");
        runEdges(9, 21, 2'd0, rotSeq, steps, wraps, holds);
        checkValue("rotSteps", 32'(steps), 32'd9);
        checkValue("rotWraps", 32'(wraps), 32'd1);

        $display("[TB] BOUNCE");
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0);
        checkValue("bounceChgLeds", 32'(leds), 32'h01);
        runEdges(16, 2, 2'd2, bounceSeq, steps, wraps, holds);
        checkValue("bounceSteps", 32'(steps), 32'd16);
        checkValue("bounceWraps", 32'(wraps), 32'd1);
        checkValue("bounceEndHeld", 32'(holds), 32'd0);

        $display("[TB] FILL");
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b0);
        checkValue("fillChgLeds", 32'(leds), 32'h01);
        runEdges(9, 2, 2'd3, fillSeq, steps, wraps, holds);
        checkValue("fillSteps", 32'(steps), 32'd9);
        checkValue("fillWraps", 32'(wraps), 32'd1);

        $display("[TB] tick held high through reset");
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
        checkOutput("rstTickHigh");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 2'd0, 1'b0);
            checkOutput("releaseTickHigh");
            checkValue("noStepAfterRelease", 32'(step_pulse), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0);
        checkValue("firstRealEdge", 32'(leds), 32'h02);

        $display("[TB] reset mid-bounce");
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0);
        runEdges(9, 2, 2'd2, bounceSeq, steps, wraps, holds);
        checkValue("bounceDescending", 32'(leds), 32'h20);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0);
        checkValue("bounceRstLeds", 32'(leds), 32'h01);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
        checkValue("bounceAfterRst", 32'({leds, step_pulse}), 32'({8'h02, 1'b1}));

        $display("[TB] randomized run");
        rT = 1'b0;
        rM = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) rT = ~rT;
            if ($urandom_range(0, 39) == 0) rM = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 299) == 0), rT, rM, ($urandom_range(0, 3) == 0));
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Downstream consumer of the square-wave timer output in the PD1 I/O design.
- Detects rising edges of the timer's periodic output and advances an LED pattern one step per edge.
- Pattern is selected by board switches and can be frozen by a pause input.
- Drives the board LEDs directly and emits one-cycle step/wrap pulses for later stages (e.g. a step counter on the 7-seg display).

Parameters:
WIDTH, 8, number of LEDs driven; legal range 2..32.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
tick_in  input  1  square wave from the timer, same clock domain; rising edge = one step request.
mode  input  2  pattern select: 00 ROT_L, 01 ROT_R, 10 BOUNCE, 11 FILL.
pause  input  1  1 = ignore step requests.
leds  output  WIDTH  registered LED pattern.
step_pulse  output  1  registered; high one cycle when leds advanced.
wrap_pulse  output  1  registered; high one cycle when the pattern completes a cycle.

Behaviour:
- Reset (rst=1 at posedge; overrides everything):
  - leds=1 (bit0 only); dir=LEFT; fill_idx=0.
  - step_pulse=0; wrap_pulse=0; mode_q=mode.
  - tick_q=1, so tick_in already high on reset release does not count as an edge.
- Edge detect: edge = tick_in & ~tick_q; tick_q<=tick_in every cycle.
  - leds update at the same posedge that first samples tick_in=1, i.e. 1 clk latency, output registered.
- Mode change: mode_q<=mode every cycle; chg = (mode != mode_q).
  - On chg: leds<=1, dir<=LEFT, fill_idx<=0, step_pulse<=0, wrap_pulse<=0.
  - An edge in the same cycle is dropped; mode change wins.
- step = edge & ~pause & ~chg. Edges during pause are lost, not queued. pause has no effect on leds otherwise.
- On step, step_pulse<=1. Otherwise step_pulse<=0 and wrap_pulse<=0.
- Mode ROT_L:
  - leds<=rotate left by 1; bit WIDTH-1 wraps to bit0.
  - wrap_pulse<=1 when bit WIDTH-1 was set.
- Mode ROT_R:
  - leds<=rotate right by 1; bit0 wraps to bit WIDTH-1.
  - wrap_pulse<=1 when bit0 was set.
- Mode BOUNCE (single lit LED, state machine dir ∈ {LEFT, RIGHT}):
  - LEFT: shift left. On reaching bit WIDTH-1, dir<=RIGHT.
  - RIGHT: shift right. On reaching bit0, dir<=LEFT and wrap_pulse<=1.
  - Never leaves the edge LED lit for two steps.
- Mode FILL:
  - fill_idx counts 0..WIDTH-1; leds = (2^(fill_idx+1))-1.
  - Step from fill_idx=WIDTH-1 (all ones) goes to fill_idx=0 (leds=1) with wrap_pulse<=1.
- Robustness: if leds is not a valid pattern for the current mode, the next step reloads leds=1 and clears dir/fill_idx. Example: non-one-hot in ROT/BOUNCE, which can only arise from a glitch.
- Width rules:
  - fill_idx is clog2(WIDTH) bits.
  - FILL pattern is computed at WIDTH bits with no truncation warnings.

Decomposition:
- Shared include file pd1_defs.vh:
  - mode encodings MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_BOUNCE=2'b10, MODE_FILL=2'b11;
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
- One sub-module, rise_edge_detect:
  - ports clk, rst, din, pulse;
  - reset value of its register is a parameter, set to 1 here.
  - Reused later for debounced buttons.

Test Plan:
- Reset, mode=00, drive tick_in period 42 clk (high 21), 9 rising edges.
  - leds sequence 01,02,04,...,80,01.
  - wrap_pulse exactly once, at the 80→01 step.
  - step_pulse 9 times, each 1 clk after the tick_in rise.
- mode=10, 16 edges.
  - leds 01,02,...,80,40,...,01,02.
  - wrap_pulse only on the 02→01 step.
  - 80 never held for two steps.
- mode=11, 9 edges.
  - leds 01,03,07,0F,1F,3F,7F,FF,01.
  - wrap_pulse on FF→01.
- Pause and edge/mode collisions, from leds=04 in mode 00:
  - pause=1 across 3 edges → leds stay 04, no step_pulse.
  - Release pause → next edge gives 08.
  - Change mode to 01 in the same cycle as an edge → leds=01, step_pulse=0.
  - Next edge → 80, wrap_pulse=1.
- Reset interactions:
  - Hold tick_in=1 during and after rst deassert → no step until tick_in falls and rises again.
  - Assert rst mid-BOUNCE while dir=RIGHT → leds=01, dir=LEFT; next edge gives 02.
